// File: rtl/stash_pkg.sv
// stash_pkg
// Shared definitions for the Stash circular buffer and its input sampler.
//   SAMPLE_W   : width of one stored sample (matches the switch bank)
//   dbState_e  : debounce FSM states used by btn_debouncer
package stash_pkg;

    localparam int SAMPLE_W = 8;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        PRESS_CHK   = 2'd1,
        HELD        = 2'd2,
        RELEASE_CHK = 2'd3
    } dbState_e;

endpackage

// File: rtl/btn_debouncer.sv
// btn_debouncer
// Synchronizes one raw push button and debounces it with a four-state FSM.
// A level change is accepted only after DEBOUNCE_CYCLES consecutive stable
// synchronized samples.
// Ports:
//   clk         : system clock
//   reset       : synchronous, active-high reset
//   btn         : raw asynchronous button, active-high
//   press_pulse : one-cycle strobe in the cycle the press is accepted
//                 (decoded from registered state, so the caller registers it
//                 on the same edge the FSM enters HELD)
//   held        : high while the FSM sits in HELD
module btn_debouncer
    import stash_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press_pulse,
    output logic held
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [1:0]    sync_q;
    logic          synced;
    dbState_e      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    assign synced = sync_q[1];

    // Two-flop synchronizer; everything downstream sees only sync_q[1].
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], btn};
        end
    end

    // Debounce FSM. The counter holds the number of stable samples seen so
    // far, so the accepting transition fires when it would reach CNT_MAX.
    // The >= compare keeps the counter saturating rather than wrapping.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        press_pulse = 1'b0;
        case (state_q)
            IDLE: begin
                if (synced) begin
                    state_d = PRESS_CHK;
                    cnt_d   = CNT_ONE;
                end
            end
            PRESS_CHK: begin
                if (!synced) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q >= CNT_MAX - CNT_ONE) begin
                    state_d     = HELD;
                    cnt_d       = CNT_MAX;
                    press_pulse = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HELD: begin
                if (!synced) begin
                    state_d = RELEASE_CHK;
                    cnt_d   = CNT_ONE;
                end
            end
            RELEASE_CHK: begin
                if (synced) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q >= CNT_MAX - CNT_ONE) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and counter registers; reset discards any partial count.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign held = (state_q == HELD);

endmodule

// File: rtl/stash_input_sampler.sv
// stash_input_sampler
// Front end for the Stash buffer: debounces the store and next buttons,
// synchronizes the switch bank and emits registered sample/next strobes.
// Optional feature macro: STASH_SAMPLER_AUTO_REPEAT_EN (auto-repeat of
// next_sample while the next button is held).
// Ports:
//   clk          : system clock
//   reset        : synchronous, active-high reset
//   btn_store    : raw store button
//   btn_next     : raw next button
//   sw           : raw switch bank
//   sample       : switch value captured at the last store event
//   sample_valid : one-cycle pulse per accepted store press
//   next_sample  : one-cycle pulse per accepted next press (or repeat)
module stash_input_sampler
    import stash_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_CYCLES   = 50000000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                btn_store,
    input  logic                btn_next,
    input  logic [SAMPLE_W-1:0] sw,
    output logic [SAMPLE_W-1:0] sample,
    output logic                sample_valid,
    output logic                next_sample
);

    logic [SAMPLE_W-1:0] swSync1_q, swSync2_q;
    logic [SAMPLE_W-1:0] sample_q, sample_d;
    logic                sampleValid_q, sampleValid_d;
    logic                nextSample_q, nextSample_d;
    logic                storeFire, storeHeld;
    logic                nextFire, nextHeld;
    logic                nextAny;
    logic                unusedStoreHeld;

    btn_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) storeDeb (
        .clk         (clk),
        .reset       (reset),
        .btn         (btn_store),
        .press_pulse (storeFire),
        .held        (storeHeld)
    );

    btn_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) nextDeb (
        .clk         (clk),
        .reset       (reset),
        .btn         (btn_next),
        .press_pulse (nextFire),
        .held        (nextHeld)
    );

    // The store button never repeats, so its held flag has no consumer.
    assign unusedStoreHeld = storeHeld;

`ifdef STASH_SAMPLER_AUTO_REPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES);
    localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_CYCLES - 1);

    logic [RW-1:0] rptCnt_q, rptCnt_d;
    logic          rptFire;

    // Repeat counter: cleared by the initial press and by every repeat,
    // advances only while HELD, so a bounce into RELEASE_CHK freezes it and
    // a return to HELD resumes from where it stopped.
    always_comb begin
        rptCnt_d = rptCnt_q;
        rptFire  = 1'b0;
        if (nextFire) begin
            rptCnt_d = '0;
        end else if (nextHeld) begin
            if (rptCnt_q == RPT_LAST) begin
                rptFire  = 1'b1;
                rptCnt_d = '0;
            end else begin
                rptCnt_d = rptCnt_q + RW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rptCnt_q <= '0;
        end else begin
            rptCnt_q <= rptCnt_d;
        end
    end

    assign nextAny = nextFire | rptFire;
`else
    logic        unusedNextHeld;
    logic [31:0] unusedRepeatCycles;

    assign unusedNextHeld     = nextHeld;
    assign unusedRepeatCycles = 32'(REPEAT_CYCLES);
    assign nextAny            = nextFire;
`endif

    // Switch-bank synchronizer, two flops per bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            swSync1_q <= '0;
            swSync2_q <= '0;
        end else begin
            swSync1_q <= sw;
            swSync2_q <= swSync1_q;
        end
    end

    // Output next-state: a store wins a same-cycle collision and the next
    // strobe is simply dropped so Stash never sees both at once.
    always_comb begin
        sample_d      = sample_q;
        sampleValid_d = storeFire;
        nextSample_d  = nextAny & ~storeFire;
        if (storeFire) begin
            sample_d = swSync2_q;
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            sample_q      <= '0;
            sampleValid_q <= 1'b0;
            nextSample_q  <= 1'b0;
        end else begin
            sample_q      <= sample_d;
            sampleValid_q <= sampleValid_d;
            nextSample_q  <= nextSample_d;
        end
    end

    assign sample       = sample_q;
    assign sample_valid = sampleValid_q;
    assign next_sample  = nextSample_q;

endmodule
